dispatch_demux5: RTL and testbench

- Single-entry pipelined 1-to-5 dispatcher. It takes one 32-bit payload plus a 5-bit one-hot destination select over a valid/ready handshake, and delivers the payload to exactly one of five consumers (slot 0..4), each with its own valid/ready pair.
- Sits between decode/issue and the five execution ports. It is the fan-out counterpart of the one-hot 5:1 result mux that merges those ports back.

---
 rtl/dispatch_if.sv | 25 ++
 rtl/dispatch_demux5.sv | 95 +++++++++
 tb/tb_dispatch_demux5.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dispatch_if.sv
// Handshake bundle between the issue stage and the five execution-port consumers.
interface dispatch_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NDST = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [NDST-1:0] in_sel;
  logic [NDST-1:0] out_valid;
  logic [NDST-1:0] out_ready;
  logic [DW-1:0]   out_data;

  // master drives the upstream side and consumes the per-slot outputs
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave is the dispatcher itself
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dispatch_demux5.sv
// Single-entry 1-to-5 one-hot dispatcher with full-throughput valid/ready.
// Optional per-slot issue counters enabled by `define DISPATCH_PERF_CNT_EN.
module dispatch_demux5 #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NDST = 5
) (
  input  logic        clk,
  input  logic        rst,
  dispatch_if.slave   bus,
  input  logic        flush,
  output logic        sel_err,
  input  logic [2:0]  cnt_sel,
  output logic [31:0] cnt_data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q;
  logic [DW-1:0]   data_q;
  logic [NDST-1:0] sel_q;
  logic            err_q;

  logic            full;
  logic            out_fire;
  logic            in_fire;
  logic            sel_legal;
  logic [NDST-1:0] deliver;

  assign full      = (state_q == FULL);
  assign deliver   = bus.out_valid & bus.out_ready;
  assign out_fire  = |deliver;
  assign sel_legal = (bus.in_sel != '0) && ((bus.in_sel & (bus.in_sel - NDST'(1))) == '0);

  // out_ready -> in_ready is a deliberate combinational path for zero-bubble streaming
  assign bus.in_ready  = ~flush & (~full | out_fire);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = {NDST{full}} & sel_q;
  assign bus.out_data  = data_q;
  assign sel_err       = err_q;

  // Entry state: load on legal accept, drain on delivery, hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= in_fire & ~sel_legal;
      if (in_fire && sel_legal) begin
        state_q <= FULL;
        data_q  <= bus.in_data;
        sel_q   <= bus.in_sel;
      end else if (out_fire) begin
        state_q <= EMPTY;
      end
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] cnt_q [NDST];

  // Per-slot delivery counters; only reset clears them, flush leaves them alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NDST); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NDST); i++) begin
        if (deliver[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    cnt_data = '0;
    case (cnt_sel)
      3'd0:    cnt_data = cnt_q[0];
      3'd1:    cnt_data = cnt_q[1];
      3'd2:    cnt_data = cnt_q[2];
      3'd3:    cnt_data = cnt_q[3];
      3'd4:    cnt_data = cnt_q[4];
      default: cnt_data = '0;
    endcase
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_data       = '0;
`endif

endmodule

// File: tb/tb_dispatch_demux5.sv
// Directed self-checking bench for dispatch_demux5.
module tb_dispatch_demux5;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        sel_err;
  logic [2:0]  cnt_sel;
  logic [31:0] cnt_data;
  int          checks = 0;
  int          errors = 0;

  dispatch_if #(.DW(32), .NDST(5)) bus ();

  dispatch_demux5 #(.DW(32), .NDST(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .flush    (flush),
    .sel_err  (sel_err),
    .cnt_sel  (cnt_sel),
    .cnt_data (cnt_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
`ifdef DISPATCH_PERF_CNT_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [4:0] r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sel    = s;
    bus.out_ready = r;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    cnt_sel = 3'd0;
    drive(1'b0, 32'h0, 5'b0, 5'b0);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  bus.out_data, 32'h0);
    chk("rst_sel_err",   32'(sel_err), 32'h0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'h1);
    chk("rst_cnt",       cnt_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single transfer to slot 2, then drain
    drive(1'b1, 32'hDEADBEEF, 5'b00100, 5'b00000);
    #1 chk("t1_in_ready_empty", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("t1_out_valid", 32'(bus.out_valid), 32'h04);
    chk("t1_out_data",  bus.out_data, 32'hDEADBEEF);
    chk("t1_in_ready_full", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 5'b00100;
    #1 chk("t1_in_ready_drain", 32'(bus.in_ready), 32'h1);
    tick();
    bus.out_ready = 5'b0;
    #1 chk("t1_empty_after", 32'(bus.out_valid), 32'h0);

    // back-to-back streaming, rotating one-hot select
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i + 1), 5'(1 << (i % 5)), 5'b11111);
      #1;
      chk("s_in_ready", 32'(bus.in_ready), 32'h1);
      if (i > 0) begin
        chk("s_out_valid", 32'(bus.out_valid), 32'(1 << ((i - 1) % 5)));
        chk("s_out_data",  bus.out_data, 32'(i));
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("s_last_valid", 32'(bus.out_valid), 32'h04);
    chk("s_last_data",  bus.out_data, 32'h8);
    tick();
    #1 chk("s_drained", 32'(bus.out_valid), 32'h0);

    // backpressure: slot 3 held while its ready is low
    drive(1'b1, 32'hA5A5A5A5, 5'b01000, 5'b10111);
    tick();
    bus.in_data = 32'h12345678;
    bus.in_sel  = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'h08);
      chk("bp_out_data",  bus.out_data, 32'hA5A5A5A5);
      chk("bp_in_ready",  32'(bus.in_ready), 32'h0);
      tick();
    end
    bus.out_ready = 5'b01000;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 5'b00001;
    #1;
    chk("bp_next_valid", 32'(bus.out_valid), 32'h01);
    chk("bp_next_data",  bus.out_data, 32'h12345678);
    tick();
    bus.out_ready = 5'b0;

    // illegal selects: zero, then two bits
    drive(1'b1, 32'h0000FFFF, 5'b00000, 5'b00000);
    #1 chk("ill0_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("ill0_sel_err",   32'(sel_err), 32'h1);
    chk("ill0_out_valid", 32'(bus.out_valid), 32'h0);
    tick();
    #1 chk("ill0_err_pulse", 32'(sel_err), 32'h0);
    drive(1'b1, 32'h0000EEEE, 5'b00011, 5'b11111);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("ill2_sel_err",   32'(sel_err), 32'h1);
    chk("ill2_out_valid", 32'(bus.out_valid), 32'h0);
    tick();
    #1 chk("ill2_err_pulse", 32'(sel_err), 32'h0);
    bus.out_ready = 5'b0;
    // slot0: payloads 1,6,0x12345678; slot2: DEADBEEF,3,8; slot3: 4,A5A5A5A5
    cnt_sel = 3'd0; #1 chk("cnt_pre_slot0", cnt_data, cexp(3));
    cnt_sel = 3'd2; #1 chk("cnt_pre_slot2", cnt_data, cexp(3));
    cnt_sel = 3'd3; #1 chk("cnt_pre_slot3", cnt_data, cexp(2));
    cnt_sel = 3'd1; #1 chk("cnt_pre_slot1", cnt_data, cexp(2));
    tick();

    // flush discards a held entry and blocks acceptance that cycle
    drive(1'b1, 32'h000000F1, 5'b00010, 5'b00000);
    tick();
    bus.in_valid = 1'b0;
    #1 chk("fl_held", 32'(bus.out_valid), 32'h02);
    flush = 1'b1;
    drive(1'b1, 32'h000000F2, 5'b00001, 5'b00000);
    #1 chk("fl_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("fl_out_valid", 32'(bus.out_valid), 32'h0);
    chk("fl_in_ready_after", 32'(bus.in_ready), 32'h1);

    // asynchronous reset between edges
    drive(1'b1, 32'h00000077, 5'b00100, 5'b00000);
    tick();
    bus.in_valid = 1'b0;
    #1 chk("ar_held", 32'(bus.out_valid), 32'h04);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'h0);
    chk("ar_in_ready",  32'(bus.in_ready), 32'h1);
    chk("ar_out_data",  bus.out_data, 32'h0);
    cnt_sel = 3'd2; #1 chk("ar_cnt_cleared", cnt_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // counters: three to slot 0, two to slot 4
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(32'h100 + i), (i < 3) ? 5'b00001 : 5'b10000, 5'b11111);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 5'b0;
    cnt_sel = 3'd0; #1 chk("cnt_slot0", cnt_data, cexp(3));
    cnt_sel = 3'd4; #1 chk("cnt_slot4", cnt_data, cexp(2));
    cnt_sel = 3'd6; #1 chk("cnt_sel6",  cnt_data, 32'h0);
    cnt_sel = 3'd2; #1 chk("cnt_slot2", cnt_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
